// File: rtl/wl_hsrx.sv
// rtl/wl_hsrx.sv - 4-phase handshake receiver with a one-word output buffer and transfer counter
module wl_hsrx #(
    parameter int DW = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          req_s,
    input  logic [DW-1:0] din,
    output logic          ack,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    input  logic          dout_rdy,
    output logic [CW-1:0] xfer_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        ACKD = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   buf_free;
    logic   capture;

    // The buffer counts as free when it is empty or is being drained on this very edge.
    always_comb begin
        buf_free  = !dout_vld || dout_rdy;
        capture   = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_s && buf_free) begin
                    capture   = 1'b1;
                    state_nxt = ACKD;
                end
            end
            ACKD: begin
                if (!req_s) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ack is its own flop loaded from the next state, so it never glitches toward the source.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state    <= IDLE;
            ack      <= 1'b0;
            dout     <= '0;
            dout_vld <= 1'b0;
            xfer_cnt <= '0;
        end else begin
            state <= state_nxt;
            ack   <= (state_nxt == ACKD);
            if (capture) begin
                dout     <= din;
                dout_vld <= 1'b1;
                xfer_cnt <= xfer_cnt + CW'(1);
            end else if (dout_vld && dout_rdy) begin
                dout_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wl_hsrx.sv
// tb/tb_wl_hsrx.sv - directed and soak bench for wl_hsrx (DW=8, CW=4)
module tb_wl_hsrx;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_b;
    logic          req_s;
    logic [DW-1:0] din;
    logic          ack;
    logic [DW-1:0] dout;
    logic          dout_vld;
    logic          dout_rdy;
    logic [CW-1:0] xfer_cnt;

    int checks   = 0;
    int failures = 0;

    wl_hsrx #(.DW(DW), .CW(CW)) dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .req_s    (req_s),
        .din      (din),
        .ack      (ack),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_rdy (dout_rdy),
        .xfer_cnt (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic chk_out(input string tag, input logic a, input logic [DW-1:0] d,
                           input logic v, input logic [CW-1:0] c);
        chk({tag, "_ack"}, 32'(ack), 32'(a));
        chk({tag, "_dout"}, 32'(dout), 32'(d));
        chk({tag, "_vld"}, 32'(dout_vld), 32'(v));
        chk({tag, "_cnt"}, 32'(xfer_cnt), 32'(c));
    endtask

    // Complete handshake with an always-ready consumer; the word must appear right after ack rises.
    task automatic xfer(input logic [DW-1:0] d);
        din   = d;
        req_s = 1'b1;
        step();
        chk("wrap_ack", 32'(ack), 32'd1);
        chk("wrap_word", 32'(dout), 32'(d));
        req_s = 1'b0;
        step();
    endtask

    logic [DW-1:0] sent_q[$];
    logic [DW-1:0] exp_w;
    int            sent;
    int            rcvd;
    int            gap;
    int            src_st;
    logic          prev_ack;
    logic          req_at_edge;

    initial begin
        rst_b    = 1'b1;
        req_s    = 1'b0;
        din      = '0;
        dout_rdy = 1'b0;
        #2;
        chk_out("reset", 1'b0, 8'h00, 1'b0, 4'd0);

        step();
        rst_b = 1'b0;

        // Basic transfer
        din      = 8'hA5;
        dout_rdy = 1'b1;
        req_s    = 1'b1;
        step();
        chk_out("basic_cap", 1'b1, 8'hA5, 1'b1, 4'd1);
        step();
        chk_out("basic_drain", 1'b1, 8'hA5, 1'b0, 4'd1);
        req_s = 1'b0;
        step();
        chk("basic_ackfall", 32'(ack), 32'd0);

        // Backpressure: second request blocked until the consumer drains
        dout_rdy = 1'b0;
        din      = 8'h11;
        req_s    = 1'b1;
        step();
        chk_out("bp_first", 1'b1, 8'h11, 1'b1, 4'd2);
        req_s = 1'b0;
        step();
        chk_out("bp_release", 1'b0, 8'h11, 1'b1, 4'd2);
        din   = 8'h22;
        req_s = 1'b1;
        step();
        chk_out("bp_blocked1", 1'b0, 8'h11, 1'b1, 4'd2);
        step();
        chk_out("bp_blocked2", 1'b0, 8'h11, 1'b1, 4'd2);
        dout_rdy = 1'b1;
        step();
        chk_out("bp_swap", 1'b1, 8'h22, 1'b1, 4'd3);
        req_s = 1'b0;
        step();
        chk_out("bp_done", 1'b0, 8'h22, 1'b0, 4'd3);

        // Held request with din changing every cycle: only the first value is taken
        dout_rdy = 1'b0;
        din      = 8'h30;
        req_s    = 1'b1;
        step();
        chk_out("held_cap", 1'b1, 8'h30, 1'b1, 4'd4);
        for (int i = 0; i < 9; i++) begin
            din = 8'h31 + 8'(i);
            step();
            chk_out("held_hold", 1'b1, 8'h30, 1'b1, 4'd4);
        end
        req_s = 1'b0;
        step();
        chk("held_ackfall", 32'(ack), 32'd0);
        dout_rdy = 1'b1;
        step();
        chk("held_drain", 32'(dout_vld), 32'd0);

        // Request dropped while blocked: no capture, no ack
        dout_rdy = 1'b0;
        din      = 8'h44;
        req_s    = 1'b1;
        step();
        req_s = 1'b0;
        step();
        din   = 8'h55;
        req_s = 1'b1;
        step();
        chk("drop_blocked_ack", 32'(ack), 32'd0);
        req_s = 1'b0;
        step();
        dout_rdy = 1'b1;
        step();
        chk_out("drop_after", 1'b0, 8'h44, 1'b0, 4'd5);
        dout_rdy = 1'b0;

        // dout_rdy with an empty buffer does nothing
        dout_rdy = 1'b1;
        step();
        step();
        chk_out("rdy_empty", 1'b0, 8'h44, 1'b0, 4'd5);
        dout_rdy = 1'b0;

        // Mid-transfer reset, then capture on the first edge after release
        din   = 8'h66;
        req_s = 1'b1;
        step();
        chk_out("mid_pre", 1'b1, 8'h66, 1'b1, 4'd6);
        rst_b = 1'b1;
        din   = 8'h77;
        #1;
        chk_out("mid_async", 1'b0, 8'h00, 1'b0, 4'd0);
        step();
        chk_out("mid_held", 1'b0, 8'h00, 1'b0, 4'd0);
        rst_b = 1'b0;
        step();
        chk_out("mid_recap", 1'b1, 8'h77, 1'b1, 4'd1);
        req_s    = 1'b0;
        dout_rdy = 1'b1;
        step();
        chk_out("mid_done", 1'b0, 8'h77, 1'b0, 4'd1);

        // Counter wrap: 15 more transfers bring the 4-bit count back to 0
        for (int i = 0; i < 15; i++) begin
            xfer(8'hC0 + 8'(i));
        end
        chk("wrap_cnt", 32'(xfer_cnt), 32'd0);
        chk("wrap_vld", 32'(dout_vld), 32'd0);

        // Random soak: 4-phase source against a random consumer
        sent        = 0;
        rcvd        = 0;
        gap         = 0;
        src_st      = 0;
        prev_ack    = ack;
        req_at_edge = 1'b0;
        for (int cyc = 0; cyc < 3000 && !(sent == 40 && src_st == 0 && sent_q.size() == 0); cyc++) begin
            if (ack !== prev_ack) begin
                chk("soak_ack_follows_req", 32'(ack), 32'(req_at_edge));
            end
            prev_ack = ack;
            dout_rdy = 1'($urandom_range(0, 1));
            if (dout_vld && dout_rdy) begin
                if (sent_q.size() == 0) begin
                    chk("soak_dup_word", 32'd1, 32'd0);
                end else begin
                    exp_w = sent_q.pop_front();
                    chk("soak_word", 32'(dout), 32'(exp_w));
                    rcvd++;
                end
            end
            case (src_st)
                0: begin
                    if (gap > 0) begin
                        gap--;
                    end else if (sent < 40) begin
                        din   = 8'($urandom);
                        sent_q.push_back(din);
                        req_s = 1'b1;
                        sent++;
                        src_st = 1;
                    end
                end
                1: begin
                    if (ack) begin
                        req_s  = 1'b0;
                        src_st = 2;
                    end
                end
                default: begin
                    if (!ack) begin
                        src_st = 0;
                        gap    = $urandom_range(0, 2);
                    end
                end
            endcase
            req_at_edge = req_s;
            step();
        end
        chk("soak_rcvd", 32'(rcvd), 32'd40);
        chk("soak_cnt", 32'(xfer_cnt), 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
